// File: rtl/fanin_tree_4_2_pkg.sv
// fanin_tree_4_2_pkg: round-robin priority type shared by the merge nodes
package fanin_tree_4_2_pkg;

   typedef enum logic {PRI_0 = 1'b0, PRI_1 = 1'b1} prio_t;

   // after serving one input the other input gets the next tie
   function automatic prio_t next_prio(input logic take_1);
      return take_1 ? PRI_0 : PRI_1;
   endfunction

endpackage

// File: rtl/fanin_tree_4_2_node.sv
// fanin_node_2: 2-input round-robin merge with one registered output slot
module fanin_node_2
   import fanin_tree_4_2_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ID_WIDTH   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid_0,
   input  logic                  in_valid_1,
   input  logic [DATA_WIDTH-1:0] in_data_0,
   input  logic [DATA_WIDTH-1:0] in_data_1,
   input  logic [ID_WIDTH-1:0]   in_id_0,
   input  logic [ID_WIDTH-1:0]   in_id_1,
   output logic                  in_ready_0,
   output logic                  in_ready_1,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ID_WIDTH-1:0]   out_id,
   input  logic                  out_ready
);

   logic  valid;
   logic  free;
   logic  take_0;
   logic  take_1;
   prio_t prio;

   // grant depends only on the sibling's valid, so ready never waits on own valid
   assign free       = !valid || out_ready;
   assign in_ready_0 = !rst && free && (!in_valid_1 || prio == PRI_0);
   assign in_ready_1 = !rst && free && (!in_valid_0 || prio == PRI_1);
   assign take_0     = in_valid_0 && in_ready_0;
   assign take_1     = in_valid_1 && in_ready_1;
   assign out_valid  = valid && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         prio  <= PRI_0;
      end else begin
         if (free) valid <= take_0 || take_1;
         if (take_0 || take_1) prio <= next_prio(take_1);
      end
   end

   always_ff @(posedge clk) begin
      if (take_0 || take_1) begin
         out_data <= take_1 ? in_data_1 : in_data_0;
         out_id   <= take_1 ? in_id_1 : in_id_0;
      end
   end

endmodule

// File: rtl/fanin_tree_4_2.sv
// fanin_tree_4_2: two-level registered round-robin fan-in of four channels
module fanin_tree_4_2 #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid_0,
   input  logic                  in_valid_1,
   input  logic                  in_valid_2,
   input  logic                  in_valid_3,
   input  logic [DATA_WIDTH-1:0] in_data_0,
   input  logic [DATA_WIDTH-1:0] in_data_1,
   input  logic [DATA_WIDTH-1:0] in_data_2,
   input  logic [DATA_WIDTH-1:0] in_data_3,
   output logic                  in_ready_0,
   output logic                  in_ready_1,
   output logic                  in_ready_2,
   output logic                  in_ready_3,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            out_id,
   input  logic                  out_ready
);

   localparam int TREE_DEPTH = 2;
   localparam int ID_WIDTH   = TREE_DEPTH;

   logic                  a_valid, a_ready, b_valid, b_ready;
   logic [DATA_WIDTH-1:0] a_data, b_data;
   logic [ID_WIDTH-2:0]   a_id, b_id;

   fanin_node_2 #(.DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH-1)) node_a (
      .clk        (clk),
      .rst        (rst),
      .in_valid_0 (in_valid_0),
      .in_valid_1 (in_valid_1),
      .in_data_0  (in_data_0),
      .in_data_1  (in_data_1),
      .in_id_0    (1'b0),
      .in_id_1    (1'b1),
      .in_ready_0 (in_ready_0),
      .in_ready_1 (in_ready_1),
      .out_valid  (a_valid),
      .out_data   (a_data),
      .out_id     (a_id),
      .out_ready  (a_ready)
   );

   fanin_node_2 #(.DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH-1)) node_b (
      .clk        (clk),
      .rst        (rst),
      .in_valid_0 (in_valid_2),
      .in_valid_1 (in_valid_3),
      .in_data_0  (in_data_2),
      .in_data_1  (in_data_3),
      .in_id_0    (1'b0),
      .in_id_1    (1'b1),
      .in_ready_0 (in_ready_2),
      .in_ready_1 (in_ready_3),
      .out_valid  (b_valid),
      .out_data   (b_data),
      .out_id     (b_id),
      .out_ready  (b_ready)
   );

   // the root prefixes the branch bit so out_id equals the channel index
   fanin_node_2 #(.DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)) node_c (
      .clk        (clk),
      .rst        (rst),
      .in_valid_0 (a_valid),
      .in_valid_1 (b_valid),
      .in_data_0  (a_data),
      .in_data_1  (b_data),
      .in_id_0    ({1'b0, a_id}),
      .in_id_1    ({1'b1, b_id}),
      .in_ready_0 (a_ready),
      .in_ready_1 (b_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_id     (out_id),
      .out_ready  (out_ready)
   );

endmodule

// File: tb/tb_fanin_tree_4_2.sv
// tb_fanin_tree_4_2: vector table, directed corner cases and a random queue scoreboard
module tb_fanin_tree_4_2;

   localparam int W = 16;

   typedef struct {
      logic       r;
      logic [3:0] v;
      logic       o;
      logic       ov;
      logic [1:0] id;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         out_ready = 1'b0;
   logic [3:0]   vld = '0;
   logic [W-1:0] dat [4];
   logic [3:0]   rdy;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic [1:0]   out_id;

   int           checks = 0;
   int           errors = 0;
   int           seq = 0;
   int           accepted = 0;
   int           max_wait = 0;
   int           wait_n [4];
   logic [3:0]   acc = '0;
   logic [W-1:0] q [4][$];
   vec_t         tbl [$];

   logic         m_ox;
   int           m_w;
   logic [W-1:0] m_exp;

   always #5 clk = ~clk;

   fanin_tree_4_2 #(.DATA_WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid_0 (vld[0]),
      .in_valid_1 (vld[1]),
      .in_valid_2 (vld[2]),
      .in_valid_3 (vld[3]),
      .in_data_0  (dat[0]),
      .in_data_1  (dat[1]),
      .in_data_2  (dat[2]),
      .in_data_3  (dat[3]),
      .in_ready_0 (rdy[0]),
      .in_ready_1 (rdy[1]),
      .in_ready_2 (rdy[2]),
      .in_ready_3 (rdy[3]),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_id     (out_id),
      .out_ready  (out_ready)
   );

   // reference: per-channel FIFOs of accepted payloads; reset discards everything in flight
   always @(negedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            q[k].delete();
            wait_n[k] = 0;
         end
      end else begin
         m_ox = out_valid && out_ready;
         if (m_ox) begin
            checks++;
            if (q[out_id].size() == 0) begin
               errors++;
               $display("FAIL out_unexpected: got id %0d data %h, required no output", out_id, out_data);
            end else begin
               m_exp = q[out_id].pop_front();
               if (out_data !== m_exp) begin
                  errors++;
                  $display("FAIL out_data ch%0d: got %h expected %h", out_id, out_data, m_exp);
               end
            end
         end
         for (int k = 0; k < 4; k++) begin
            if (vld[k]) begin
               m_w = wait_n[k] + (m_ox ? 1 : 0);
               if (rdy[k]) begin
                  q[k].push_back(dat[k]);
                  if (m_w > max_wait) max_wait = m_w;
                  wait_n[k] = 0;
               end else wait_n[k] = m_w;
            end else wait_n[k] = 0;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic half();
      #4;
      acc = vld & rdy;
      accepted += $countones(acc);
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++)
         if (acc[k]) begin
            dat[k] = {2'(k), 14'(seq)};
            seq++;
         end
   endtask

   task automatic cycle();
      half();
      edge_step();
   endtask

   task automatic add(input logic r, input logic [3:0] v, input logic o, input logic ov, input logic [1:0] id);
      vec_t t;
      t = '{r: r, v: v, o: o, ov: ov, id: id};
      tbl.push_back(t);
   endtask

   function automatic int pending();
      int s = 0;
      for (int k = 0; k < 4; k++) s += q[k].size();
      return s;
   endfunction

   initial begin
      int ids [4];
      int drain [3];
      int cyc;
      logic [W-1:0] hold;
      ids = '{0, 2, 1, 3};
      drain = '{0, 2, 1};
      for (int k = 0; k < 4; k++) begin
         dat[k] = {2'(k), 14'(seq)};
         seq++;
      end
      add(1, 4'hF, 1, 0, 0);
      add(1, 4'h0, 1, 0, 0);
      add(0, 4'b0100, 1, 0, 0);
      add(0, 4'h0, 1, 0, 0);
      add(0, 4'h0, 1, 1, 2);
      add(0, 4'h0, 1, 0, 0);
      add(0, 4'h0, 1, 0, 0);
      add(1, 4'h0, 1, 0, 0);
      add(0, 4'hF, 1, 0, 0);
      add(0, 4'hF, 1, 0, 0);
      for (int j = 0; j < 8; j++) add(0, 4'hF, 1, 1, 2'(ids[j % 4]));
      add(1, 4'h0, 1, 0, 0);
      add(0, 4'b0011, 1, 0, 0);
      add(0, 4'b0011, 1, 0, 0);
      for (int j = 0; j < 4; j++) add(0, 4'b0011, 1, 1, 2'(j % 2));
      @(posedge clk);
      #1;
      foreach (tbl[i]) begin
         rst = tbl[i].r;
         vld = tbl[i].v;
         out_ready = tbl[i].o;
         half();
         chk($sformatf("tbl%0d_out_valid", i), int'(out_valid), int'(tbl[i].ov));
         if (tbl[i].ov) chk($sformatf("tbl%0d_out_id", i), int'(out_id), int'(tbl[i].id));
         if (tbl[i].r) chk($sformatf("tbl%0d_rst_ready", i), int'(rdy), 0);
         edge_step();
      end
      // backpressure: the tree fills one slot per node, then holds steady
      rst = 1'b1;
      vld = '0;
      cycle();
      rst = 1'b0;
      out_ready = 1'b0;
      vld = 4'hF;
      accepted = 0;
      repeat (6) cycle();
      chk("bp_accepted", accepted, 3);
      half();
      chk("bp_ready_low", int'(rdy), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out_id", int'(out_id), 0);
      hold = out_data;
      edge_step();
      half();
      chk("bp_data_stable", int'(out_data), int'(hold));
      edge_step();
      vld = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         half();
         chk($sformatf("bp_drain%0d_valid", i), int'(out_valid), 1);
         chk($sformatf("bp_drain%0d_id", i), int'(out_id), drain[i]);
         edge_step();
      end
      half();
      chk("bp_drained_valid", int'(out_valid), 0);
      chk("bp_drained_pending", pending(), 0);
      edge_step();
      // reset pulse while three items are held
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      out_ready = 1'b0;
      vld = 4'hF;
      repeat (4) cycle();
      half();
      chk("rm_held_valid", int'(out_valid), 1);
      edge_step();
      rst = 1'b1;
      half();
      chk("rm_rst_out_valid", int'(out_valid), 0);
      chk("rm_rst_ready", int'(rdy), 0);
      edge_step();
      rst = 1'b0;
      out_ready = 1'b1;
      half();
      chk("rm_after_valid", int'(out_valid), 0);
      edge_step();
      half();
      chk("rm_after2_valid", int'(out_valid), 0);
      edge_step();
      half();
      chk("rm_first_valid", int'(out_valid), 1);
      chk("rm_first_id", int'(out_id), 0);
      edge_step();
      half();
      chk("rm_second_id", int'(out_id), 2);
      edge_step();
      vld = '0;
      repeat (4) cycle();
      chk("rm_drained_pending", pending(), 0);
      // random valid/stall traffic against the FIFO reference
      accepted = 0;
      max_wait = 0;
      cyc = 0;
      while ((accepted < 10000 || vld != 0 || pending() != 0) && cyc < 60000) begin
         for (int k = 0; k < 4; k++)
            if (!vld[k] || acc[k]) vld[k] = (accepted < 10000) && ($urandom_range(2, 0) != 0);
         out_ready = ($urandom_range(3, 0) != 0);
         cycle();
         cyc++;
      end
      vld = '0;
      chk("rnd_in_time", int'(cyc < 60000), 1);
      chk("rnd_items", int'(accepted >= 10000), 1);
      chk("rnd_pending", pending(), 0);
      chk("rnd_max_wait_le4", int'(max_wait <= 4), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fanin_tree_4_2.md
FANIN_TREE_4_2 -- requirements
Module: fanin_tree_4_2

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the payload width of every channel.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-004 The block SHALL have ports in_valid_0..in_valid_3, input, 1 bit each, marking a valid payload on the matching channel.
REQ-005 The block SHALL have ports in_data_0..in_data_3, input, DATA_WIDTH bits each, carrying the channel payload.
REQ-006 The block SHALL have ports in_ready_0..in_ready_3, output, 1 bit each; a transfer on channel k occurs when in_valid_k and in_ready_k are both high at a rising edge.
REQ-007 The block SHALL have port out_valid, output, 1 bit, marking a valid merged payload.
REQ-008 The block SHALL have port out_data, output, DATA_WIDTH bits, carrying the merged payload.
REQ-009 The block SHALL have port out_id, output, 2 bits, giving the source channel index of out_data.
REQ-010 The block SHALL have port out_ready, input, 1 bit; an output transfer occurs when out_valid and out_ready are both high at a rising edge.

Function
REQ-011 The block SHALL be a 2-level registered fan-in tree: node A merges ch0/ch1, node B merges ch2/ch3, and node C merges A/B to the output.
REQ-012 Each node SHALL hold one output register (valid, data, id) and SHALL accept a new item when its register is empty or is being drained in the same cycle.
REQ-013 Each node SHALL grant at most one input per cycle; input ready SHALL be (register empty OR downstream ready) AND granted.
REQ-014 Arbitration SHALL be round-robin: a lone valid input is always granted; when both inputs are valid, the input indicated by the priority bit is granted.
REQ-015 After any transfer from input k, the node's priority bit SHALL be set to the other input; it SHALL be unchanged when there is no transfer.
REQ-016 out_id SHALL be {C grant bit (0 = A, 1 = B), level-1 grant bit}, so ch0=0, ch1=1, ch2=2, ch3=3.
REQ-017 Latency SHALL be exactly 2 cycles with no contention: an item accepted at edge N gives out_valid=1 during cycle N+2.
REQ-018 Under sustained out_ready=1 and at least one continuously valid input, throughput SHALL be one item per cycle.
REQ-019 A held node register SHALL keep data and id stable while its downstream ready is low (no loss, no duplication, no reordering within a channel).
REQ-020 in_ready_k SHALL depend combinationally on in_valid of the sibling channel and on out_ready; there SHALL be no combinational path from in_data to any output.
REQ-021 With out_ready=0 the tree SHALL absorb at most 3 items (one per node) and then deassert all in_ready.

Reset
REQ-022 While rst=1, all node valid bits SHALL clear to 0, all priority bits SHALL clear to 0, and out_valid and all in_ready SHALL be 0.
REQ-023 Asserting rst mid-operation SHALL discard every held item; out_valid SHALL be 0 in the first cycle after the reset edge.
REQ-024 Data registers need not be reset; out_data and out_id SHALL be don't-care while out_valid=0.

Structure
REQ-025 The 2-input round-robin merge node SHALL be the sub-module fanin_node_2 (parameters DATA_WIDTH and ID_WIDTH), instantiated three times.
REQ-026 No shared package is required; tree depth (2) and ID width (2) SHALL be local constants of fanin_tree_4_2.

Verification
REQ-027 The bench SHALL cover single item: ch2 sends 0x00AB at edge 0 with out_ready=1 -> out_valid=1, out_data=0x00AB, out_id=2 during cycle 2 only.
REQ-028 The bench SHALL cover saturation: all four channels valid continuously with out_ready=1 -> out_id sequence 0,2,1,3,0,2,1,3 starting in cycle 2, one item per cycle.
REQ-029 The bench SHALL cover backpressure: out_ready=0 with all channels valid -> exactly 3 items accepted, then all in_ready=0 and out_data stable; releasing out_ready drains items in order with no loss.
REQ-030 The bench SHALL cover ch0 and ch1 contention only: ch0 and ch1 valid with out_ready=1 -> grants alternate 0,1,0,1 and each channel's payloads arrive in issue order.
REQ-031 The bench SHALL cover reset mid-stream: rst pulsed for 1 cycle while 3 items are held -> out_valid=0 the next cycle, the held items never appear, and priority restarts at ch0.
REQ-032 The bench SHALL run a random-stall scoreboard: 10k items with random in_valid and out_ready -> the per-channel sequences match exactly and no channel waits more than 4 output transfers while valid.
